pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the miniRV fetch stage; successor to the fixed 32-bit PC register.
- Holds the current fetch address and selects the next one from these sources, in priority order: trap vector, redirect target (branch/jump), hold (stall), sequential increment.
- Adds a boot FSM with a configurable settle time, a halt state, a pc_valid_o qualifier, and a configurable reset vector and instruction size.

Parameters:
- XLEN, 32, address width in bits
- RESET_VEC, 0, pc_o value after reset; must be INST_BYTES-aligned
- INST_BYTES, 4, sequential increment; power of two, 2 or 4
- BOOT_CYCLES, 1, cycles held in BOOT after reset; must be >= 1

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- stall_i  in  1  hold PC (no instruction accepted this cycle)
- redirect_valid_i  in  1  take redirect_target_i
- redirect_target_i  in  XLEN  branch/jump target
- trap_valid_i  in  1  take trap_vec_i; highest priority
- trap_vec_i  in  XLEN  trap handler address
- halt_i  in  1  request halt
- pc_o  out  XLEN  current fetch address, registered
- pc4_o  out  XLEN  pc_o + INST_BYTES, combinational
- pc_valid_o  out  1  pc_o is a live fetch address
- misalign_o  out  1  target misalignment flag (see Optional Feature)

Behaviour:
- One clock (clk_i). Reset rst_i is synchronous and active-high, sampled on the rising edge of clk_i. No asynchronous reset.
- Reset values:
  - pc_o = RESET_VEC
  - pc_valid_o = 0
  - misalign_o = 0
  - state = BOOT, boot counter = 0
- Reset has priority over every other input in any state, including mid-redirect or HALT.
- State BOOT:
  - pc_o is held at RESET_VEC.
  - Counter increments each cycle.
  - When the counter reaches BOOT_CYCLES-1, the next state is RUN and pc_valid_o becomes 1 on the same edge.
  - stall_i, redirect_valid_i, trap_valid_i and halt_i are ignored in BOOT.
  - With BOOT_CYCLES=1: exactly one cycle of pc_o=RESET_VEC with pc_valid_o=0, then RUN with pc_o still RESET_VEC.
- State RUN: next pc_o is chosen as follows, first match wins.
  1. trap_valid_i: trap_vec_i
  2. redirect_valid_i: redirect_target_i
  3. halt_i: pc_o held; state goes to HALT; pc_valid_o goes to 0
  4. stall_i: pc_o held
  5. otherwise: pc_o + INST_BYTES
- Trap and redirect override both stall_i and halt_i, so no control transfer is lost.
- Trap and redirect asserted together: trap wins and the redirect is dropped.
- State HALT:
  - pc_o frozen, pc_valid_o = 0.
  - Exit only through trap_valid_i (pc_o = trap_vec_i, state RUN, pc_valid_o = 1) or through reset.
  - redirect_valid_i, stall_i and halt_i are ignored.
- Latency: inputs sampled at edge k appear on pc_o after edge k. pc4_o follows pc_o in the same cycle.
- Arithmetic is modulo 2^XLEN. pc_o = 2^XLEN - INST_BYTES increments to 0 without error.
- Encoding BOOT=2'd0, RUN=2'd1, HALT=2'd2. The unused code 2'd3 recovers to BOOT on the next edge with pc_o = RESET_VEC and pc_valid_o = 0.

Optional Feature:
- Macro: PC_ALIGN_CHK_EN.
- Defined:
  - Any trap or redirect target that is taken (in RUN, or a trap in HALT) has its low log2(INST_BYTES) bits forced to 0 before loading into pc_o.
  - misalign_o pulses 1 for exactly the cycle after the edge that loaded the value, if any of those bits were nonzero; otherwise misalign_o is 0.
- Not defined:
  - Targets are loaded unmodified.
  - misalign_o is tied to 0.
- The port exists in both builds.

Test Plan:
- Reset/boot, BOOT_CYCLES=3, RESET_VEC=0x100: assert rst_i for 2 cycles, then release. pc_o=0x100 with pc_valid_o=0 for 3 cycles; then pc_valid_o=1; then pc_o=0x104, 0x108 on following edges.
- Stall versus redirect: in RUN at pc_o=0x10, stall_i=1 for 2 cycles gives pc_o=0x10, 0x10. Then stall_i=1 with redirect_valid_i=1 and target 0x80 gives pc_o=0x80, then 0x84.
- Priority: trap_valid_i=1 (vec 0x200), redirect_valid_i=1 (target 0x80) and halt_i=1 all on the same edge give pc_o=0x200, state RUN, pc_valid_o=1.
- Halt: halt_i=1 at pc_o=0x40 gives pc_o=0x40 and pc_valid_o=0. Redirect and stall toggled over 5 cycles leave pc_o at 0x40. Then trap_valid_i with vec 0x300 gives pc_o=0x300, pc_valid_o=1, then 0x304.
- Wrap and reset mid-operation: pc_o=0xFFFF_FFFC increments to 0x0000_0000. Asserting rst_i during an active redirect gives pc_o=RESET_VEC and state BOOT on the next edge.
- PC_ALIGN_CHK_EN defined, redirect target 0x86: pc_o=0x84 and misalign_o=1 for one cycle. Same test with the macro undefined: pc_o=0x86 and misalign_o=0.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the miniRV fetch stage.
//
// Holds the current fetch address and picks the next one by priority:
// trap vector, redirect target, hold (stall), sequential increment.
// After reset a BOOT phase holds RESET_VEC for BOOT_CYCLES cycles
// before fetch goes live. A halt request parks the PC until a trap.
//
// Optional build macro: PC_ALIGN_CHK_EN
//   defined   - taken trap/redirect targets have their low
//               log2(INST_BYTES) bits cleared; misalign_o pulses for
//               one cycle when any of those bits were set.
//   undefined - targets load unmodified; misalign_o is tied to 0.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   stall_i             hold PC this cycle
//   redirect_valid_i    load redirect_target_i (branch/jump)
//   redirect_target_i   redirect address
//   trap_valid_i        load trap_vec_i; highest priority, also exits HALT
//   trap_vec_i          trap handler address
//   halt_i              request halt
//   pc_o                current fetch address (registered)
//   pc4_o               pc_o + INST_BYTES (combinational)
//   pc_valid_o          pc_o is a live fetch address
//   misalign_o          taken target was misaligned (checked build only)

module pc_gen #(
    parameter int                 XLEN        = 32,
    parameter logic [XLEN-1:0]    RESET_VEC   = '0,
    parameter int                 INST_BYTES  = 4,
    parameter int                 BOOT_CYCLES = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            halt_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o,
    output logic            pc_valid_o,
    output logic            misalign_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam int              CW       = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CW-1:0]   BOOT_END = CW'(BOOT_CYCLES - 1);
    localparam logic [XLEN-1:0] STEP     = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INST_BYTES - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            load;          // a trap/redirect target is taken this cycle
    logic [XLEN-1:0] load_addr;     // the raw target being taken
    logic            mis_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        load      = 1'b0;
        load_addr = trap_vec_i;

        case (state_q)
            BOOT: begin
                pc_d    = RESET_VEC;
                valid_d = 1'b0;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == BOOT_END) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                end
            end
            RUN: begin
                // Trap and redirect beat halt/stall so no transfer is lost.
                if (trap_valid_i) begin
                    load      = 1'b1;
                    load_addr = trap_vec_i;
                end else if (redirect_valid_i) begin
                    load      = 1'b1;
                    load_addr = redirect_target_i;
                end else if (halt_i) begin
                    state_d = HALT;
                    valid_d = 1'b0;
                end else if (!stall_i) begin
                    pc_d = pc_q + STEP;
                end
            end
            HALT: begin
                if (trap_valid_i) begin
                    load      = 1'b1;
                    load_addr = trap_vec_i;
                    state_d   = RUN;
                    valid_d   = 1'b1;
                end
            end
            default: begin
                // Unused encoding: fall back to a clean boot.
                state_d = BOOT;
                cnt_d   = '0;
                pc_d    = RESET_VEC;
                valid_d = 1'b0;
            end
        endcase

`ifdef PC_ALIGN_CHK_EN
        mis_d = load && |(load_addr & LOW_MASK);
        if (load) pc_d = load_addr & ~LOW_MASK;
`else
        mis_d = 1'b0;
        if (load) pc_d = load_addr;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= BOOT;
            cnt_q   <= '0;
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    logic mis_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) mis_q <= 1'b0;
        else       mis_q <= mis_d;
    end

    assign misalign_o = mis_q;
`else
    assign misalign_o = 1'b0;

    logic unused_mis;
    assign unused_mis = mis_d;
`endif

    assign pc_o       = pc_q;
    assign pc4_o      = pc_q + STEP;
    assign pc_valid_o = valid_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    localparam int          XLEN = 32;
    localparam logic [31:0] RV   = 32'h100;
    localparam int          IB   = 4;
    localparam int          BC   = 3;

    logic        clk = 1'b0;
    logic        rst, stall, rv, tv, halt;
    logic [31:0] rt, tvec;
    logic [31:0] pc, pc4;
    logic        pcv, mis;

    int errors = 0;
    int checks = 0;

    pc_gen #(.XLEN(XLEN), .RESET_VEC(RV), .INST_BYTES(IB), .BOOT_CYCLES(BC)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .redirect_valid_i(rv), .redirect_target_i(rt),
        .trap_valid_i(tv), .trap_vec_i(tvec), .halt_i(halt),
        .pc_o(pc), .pc4_o(pc4), .pc_valid_o(pcv), .misalign_o(mis)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=booting, 1=running, 2=halted.
    int          m_mode = 0;
    int          m_left = BC;
    logic [31:0] m_pc   = RV;
    logic        m_vld  = 1'b0;
    logic        m_mis  = 1'b0;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, mid-period, the outputs must match the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc_o", pc, m_pc);
            check("pc4_o", pc4, m_pc + 32'(IB));
            check("pc_valid_o", {31'b0, pcv}, {31'b0, m_vld});
            check("misalign_o", {31'b0, mis}, {31'b0, m_mis});
        end
    end

    task automatic take(input logic [31:0] t);
`ifdef PC_ALIGN_CHK_EN
        m_pc  = t & ~32'(IB - 1);
        m_mis = (t % IB) != 0;
`else
        m_pc = t;
`endif
    endtask

    task automatic model_edge();
        m_mis = 1'b0;
        if (rst) begin
            m_mode = 0; m_left = BC; m_pc = RV; m_vld = 1'b0;
        end else if (m_mode == 0) begin
            m_left--;
            m_pc = RV;
            if (m_left == 0) begin m_mode = 1; m_vld = 1'b1; end
        end else if (m_mode == 1) begin
            if (tv)         take(tvec);
            else if (rv)    take(rt);
            else if (halt)  begin m_mode = 2; m_vld = 1'b0; end
            else if (!stall) m_pc = m_pc + 32'(IB);
        end else begin
            if (tv) begin take(tvec); m_mode = 1; m_vld = 1'b1; end
        end
    endtask

    // Drive inputs for the next edge, advance the model with that edge.
    task automatic step(input logic r, input logic s, input logic rvi, input logic [31:0] rti,
                        input logic tvi, input logic [31:0] tvv, input logic h);
        rst = r; stall = s; rv = rvi; rt = rti; tv = tvi; tvec = tvv; halt = h;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(); step(0, 0, 0, 32'h0, 0, 32'h0, 0); endtask

    initial begin
        rst = 1; stall = 0; rv = 0; rt = '0; tv = 0; tvec = '0; halt = 0;

        // Reset / boot
        step(1, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_pc", pc, 32'h100);
        check("rst_vld", {31'b0, pcv}, 32'h0);
        check("rst_mis", {31'b0, mis}, 32'h0);
        idle(); check("boot1_vld", {31'b0, pcv}, 32'h0);
        idle(); check("boot2_vld", {31'b0, pcv}, 32'h0);
        idle(); check("run_vld", {31'b0, pcv}, 32'h1); check("run_pc", pc, 32'h100);
        idle(); check("seq1", pc, 32'h104);
        idle(); check("seq2", pc, 32'h108);

        // Stall vs redirect
        step(0, 0, 1, 32'h10, 0, 0, 0); check("redir10", pc, 32'h10);
        step(0, 1, 0, 0, 0, 0, 0);      check("stall1", pc, 32'h10);
        step(0, 1, 0, 0, 0, 0, 0);      check("stall2", pc, 32'h10);
        step(0, 1, 1, 32'h80, 0, 0, 0); check("stall_redir", pc, 32'h80);
        idle();                         check("after_redir", pc, 32'h84);

        // Priority: trap over redirect over halt
        step(0, 0, 1, 32'h80, 1, 32'h200, 1);
        check("prio_pc", pc, 32'h200);
        check("prio_vld", {31'b0, pcv}, 32'h1);
        idle(); check("prio_next", pc, 32'h204);

        // Halt
        step(0, 0, 1, 32'h40, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        check("halt_pc", pc, 32'h40);
        check("halt_vld", {31'b0, pcv}, 32'h0);
        for (int i = 0; i < 5; i++) step(0, i[0], ~i[0], 32'h500, 0, 0, i[1]);
        check("halt_frozen", pc, 32'h40);
        step(0, 0, 0, 0, 1, 32'h300, 0);
        check("halt_exit_pc", pc, 32'h300);
        check("halt_exit_vld", {31'b0, pcv}, 32'h1);
        idle(); check("halt_exit_seq", pc, 32'h304);

        // Wrap
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        check("pc4_wrap", pc4, 32'h0);
        idle(); check("wrap", pc, 32'h0);

        // Reset during active redirect, with noise on inputs during boot
        step(1, 0, 1, 32'h700, 0, 0, 0);
        check("rst_mid_pc", pc, 32'h100);
        check("rst_mid_vld", {31'b0, pcv}, 32'h0);
        step(0, 1, 1, 32'h900, 1, 32'h940, 1); check("boot_ignore", pc, 32'h100);
        idle(); idle();
        check("reboot_vld", {31'b0, pcv}, 32'h1);

        // Misaligned redirect target
        step(0, 0, 1, 32'h86, 0, 0, 0);
`ifdef PC_ALIGN_CHK_EN
        check("mis_pc", pc, 32'h84);
        check("mis_flag", {31'b0, mis}, 32'h1);
`else
        check("mis_pc", pc, 32'h86);
        check("mis_flag", {31'b0, mis}, 32'h0);
`endif
        idle(); check("mis_pulse_end", {31'b0, mis}, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(3) != 0) b[1:0] = 2'b00;
            step($urandom_range(49) == 0, $urandom_range(3) == 0,
                 $urandom_range(5) == 0, a,
                 $urandom_range(9) == 0, b,
                 $urandom_range(19) == 0);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
